// File: rtl/vram_sched.sv
// vram_sched: time-multiplexes one true-dual-port video RAM between a CPU/IO
// port and a burst of LANES VGA fetch lanes.
//
// A burst snapshots every lane address on an accepted vga_go. It then issues
// one lane pair per cycle: port A reads lane k and port B reads lane
// k+LANES/2. Next it waits RD_LAT cycles for the last data to return. IO is
// stalled while lane pairs are issued. IO is served on port A in IDLE and
// DRAIN, and IO reads may return after the burst has finished.
//
// Ports
//   clk_100              system clock, rising edge
//   rst                  synchronous active-high reset
//   io_addr/io_wdata     IO address / write data
//   io_we/io_re          IO write/read request levels, held until io_ack
//   io_ack               request issued to port A this cycle (combinational)
//   io_rdata/io_rvalid   IO read result register / update pulse
//   vga_addr             LANES packed lane addresses, sampled on accepted go
//   vga_go               burst request, honoured in IDLE only
//   vga_busy             burst in ISSUE or DRAIN (combinational)
//   vga_rdata/vga_done   LANES packed lane results / burst complete pulse
//
// Parameters: LANES even in 2..16, RD_LAT >= 2. The RAM holds RD_LAT-1 read
// stages, and the result registers below form the final stage. As a result,
// read data is visible RD_LAT cycles after the read is issued.
//
// state | meaning
// IDLE  | IO on port A, waiting for vga_go
// ISSUE | one lane pair per cycle on ports A/B, IO stalled
// DRAIN | RD_LAT cycles for lane data to return, IO on port A
module vram_sched #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int LANES  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                      clk_100,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         io_addr,
  input  logic [DATA_W-1:0]         io_wdata,
  input  logic                      io_we,
  input  logic                      io_re,
  output logic                      io_ack,
  output logic [DATA_W-1:0]         io_rdata,
  output logic                      io_rvalid,
  input  logic [LANES*ADDR_W-1:0]   vga_addr,
  input  logic                      vga_go,
  output logic                      vga_busy,
  output logic [LANES*DATA_W-1:0]   vga_rdata,
  output logic                      vga_done
);

  localparam int HALF = LANES / 2;
  localparam int LW   = $clog2(LANES);
  localparam int PIPE = RD_LAT - 1;
  localparam int CW   = $clog2(RD_LAT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e                         state_q, state_d;
  logic [LW-1:0]                  pair_q, pair_d;
  logic [CW-1:0]                  drain_q, drain_d;
  logic [LANES-1:0][ADDR_W-1:0]   snap_q;
  logic [LANES-1:0][DATA_W-1:0]   lane_q;
  logic [DATA_W-1:0]              io_rdata_q;
  logic                           io_rvalid_q;
  logic                           vga_done_q;

  logic [LW-1:0]                  lane_a, lane_b;
  logic                           a_en, a_we, b_en, io_rd_issue;
  logic [ADDR_W-1:0]              a_addr, b_addr;
  logic [DATA_W-1:0]              a_rdata, b_rdata;

  // Per-slot tags: IO read on A, lane read on A, lane read on B.
  logic                           tag_io_q [PIPE];
  logic                           tag_la_q [PIPE];
  logic [LW-1:0]                  tag_ia_q [PIPE];
  logic                           tag_lb_q [PIPE];
  logic [LW-1:0]                  tag_ib_q [PIPE];

  // Dual-port video RAM. Port B is read-only. RAM contents survive reset.
  logic [DATA_W-1:0]              ram_q    [2**ADDR_W];
  logic [DATA_W-1:0]              a_pipe_q [PIPE];
  logic [DATA_W-1:0]              b_pipe_q [PIPE];

  always_ff @(posedge clk_100) begin
    if (a_en && a_we) ram_q[a_addr] <= io_wdata;
    if (a_en && !a_we) a_pipe_q[0] <= ram_q[a_addr];
    if (b_en) b_pipe_q[0] <= ram_q[b_addr];
    for (int i = 1; i < PIPE; i++) begin
      a_pipe_q[i] <= a_pipe_q[i-1];
      b_pipe_q[i] <= b_pipe_q[i-1];
    end
  end

  assign a_rdata = a_pipe_q[PIPE-1];
  assign b_rdata = b_pipe_q[PIPE-1];

  // FSM state register
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      drain_q <= drain_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (vga_go) begin
          state_d = S_ISSUE;
          pair_d  = '0;
        end
      end
      S_ISSUE: begin
        if (pair_q == LW'(HALF - 1)) begin
          state_d = S_DRAIN;
          pair_d  = '0;
          drain_d = CW'(RD_LAT - 1);
        end else begin
          pair_d = pair_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_IDLE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: port A/B control and the two decoded outputs
  assign lane_a = pair_q;
  assign lane_b = pair_q + LW'(HALF);

  always_comb begin
    io_ack   = 1'b0;
    a_en     = 1'b0;
    a_we     = 1'b0;
    a_addr   = io_addr;
    b_en     = 1'b0;
    b_addr   = snap_q[lane_b];
    vga_busy = (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      a_en   = 1'b1;
      a_addr = snap_q[lane_a];
      b_en   = 1'b1;
    end else if (!rst && (io_we || io_re)) begin
      // A write wins when both requests are high.
      io_ack = 1'b1;
      a_en   = 1'b1;
      a_we   = io_we;
    end
  end

  assign io_rd_issue = io_ack && !io_we;

  always_ff @(posedge clk_100) begin
    if (state_q == S_IDLE && vga_go) snap_q <= vga_addr;
  end

  // Read-return steering. Reset drops every in-flight tag, so no stale
  // result can land after a reset.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        tag_io_q[i] <= 1'b0;
        tag_la_q[i] <= 1'b0;
        tag_ia_q[i] <= '0;
        tag_lb_q[i] <= 1'b0;
        tag_ib_q[i] <= '0;
      end
      io_rdata_q  <= '0;
      io_rvalid_q <= 1'b0;
      lane_q      <= '0;
      vga_done_q  <= 1'b0;
    end else begin
      tag_io_q[0] <= io_rd_issue;
      tag_la_q[0] <= (state_q == S_ISSUE);
      tag_ia_q[0] <= lane_a;
      tag_lb_q[0] <= (state_q == S_ISSUE);
      tag_ib_q[0] <= lane_b;
      for (int i = 1; i < PIPE; i++) begin
        tag_io_q[i] <= tag_io_q[i-1];
        tag_la_q[i] <= tag_la_q[i-1];
        tag_ia_q[i] <= tag_ia_q[i-1];
        tag_lb_q[i] <= tag_lb_q[i-1];
        tag_ib_q[i] <= tag_ib_q[i-1];
      end
      io_rvalid_q <= tag_io_q[PIPE-1];
      if (tag_io_q[PIPE-1]) io_rdata_q <= a_rdata;
      if (tag_la_q[PIPE-1]) lane_q[tag_ia_q[PIPE-1]] <= a_rdata;
      if (tag_lb_q[PIPE-1]) lane_q[tag_ib_q[PIPE-1]] <= b_rdata;
      vga_done_q <= (state_q == S_DRAIN) && (drain_q == '0);
    end
  end

  assign io_rdata  = io_rdata_q;
  assign io_rvalid = io_rvalid_q;
  assign vga_rdata = lane_q;
  assign vga_done  = vga_done_q;

endmodule

// File: tb/tb_vram_sched.sv
module tb_vram_sched;
  parameter int DATA_W = 8;
  parameter int ADDR_W = 14;
  parameter int LANES  = 8;
  parameter int RD_LAT = 2;
  localparam int HALF = LANES / 2;
  localparam int D    = HALF + RD_LAT + 1;

  typedef logic [511:0] w_t;

  logic                      clk_100 = 1'b0;
  logic                      rst;
  logic [ADDR_W-1:0]         io_addr;
  logic [DATA_W-1:0]         io_wdata;
  logic                      io_we, io_re;
  logic                      io_ack;
  logic [DATA_W-1:0]         io_rdata;
  logic                      io_rvalid;
  logic [LANES*ADDR_W-1:0]   vga_addr;
  logic                      vga_go;
  logic                      vga_busy;
  logic [LANES*DATA_W-1:0]   vga_rdata;
  logic                      vga_done;

  vram_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .RD_LAT(RD_LAT)) dut (
    .clk_100(clk_100), .rst(rst),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_ack(io_ack), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .vga_addr(vga_addr), .vga_go(vga_go), .vga_busy(vga_busy),
    .vga_rdata(vga_rdata), .vga_done(vga_done)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [DATA_W-1:0]       mm [int];
  bit                      armed = 1'b0;
  bit                      active = 1'b0;
  int                      g = 0;
  int                      due_q [$];
  logic [DATA_W-1:0]       dat_q [$];
  logic [DATA_W-1:0]       last_rd = '0;
  logic [LANES*DATA_W-1:0] lanes_cur = '0;
  logic [LANES*DATA_W-1:0] lanes_pend = '0;

  function automatic logic [DATA_W-1:0] mrd(input int a);
    return mm.exists(a) ? mm[a] : '0;
  endfunction

  always @(negedge clk_100) begin : model
    int n;
    bit issue, busy, done, ack, rv;
    n     = cyc;
    issue = active && n >= g + 1 && n <= g + HALF;
    busy  = active && n >= g + 1 && n <= g + HALF + RD_LAT;
    done  = active && n == g + D;
    ack   = !rst && (io_we || io_re) && !issue;
    rv    = due_q.size() > 0 && due_q[0] == n;
    if (rv) begin
      last_rd = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (done) begin
      lanes_cur = lanes_pend;
      active    = 1'b0;
    end
    if (armed) begin
      chk("m_io_ack", w_t'(io_ack), w_t'(ack));
      chk("m_vga_busy", w_t'(vga_busy), w_t'(busy));
      chk("m_vga_done", w_t'(vga_done), w_t'(done));
      chk("m_io_rvalid", w_t'(io_rvalid), w_t'(rv));
      chk("m_io_rdata", w_t'(io_rdata), w_t'(last_rd));
      if (!busy) chk("m_vga_rdata", w_t'(vga_rdata), w_t'(lanes_cur));
    end
    if (ack) begin
      if (io_we) mm[int'(io_addr)] = io_wdata;
      else begin
        due_q.push_back(n + RD_LAT);
        dat_q.push_back(mrd(int'(io_addr)));
      end
    end
    if (!rst && vga_go && !active) begin
      g      = n;
      active = 1'b1;
      for (int k = 0; k < LANES; k++)
        lanes_pend[k*DATA_W +: DATA_W] = mrd(int'(vga_addr[k*ADDR_W +: ADDR_W]));
    end
    if (rst) begin
      armed     = 1'b1;
      active    = 1'b0;
      due_q.delete();
      dat_q.delete();
      last_rd   = '0;
      lanes_cur = '0;
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  // Call with vga_go about to be raised in the current cycle (cycle 0 of the
  // burst). rd_addr >= 0 also holds an IO read from cycle 1 until its ack.
  task automatic burst(input string tag, input logic [LANES*ADDR_W-1:0] a,
                       input logic [LANES*DATA_W-1:0] exp, input bit scramble,
                       input int rd_addr, input bit exp_go_ack);
    vga_addr = a;
    vga_go   = 1'b1;
    @(negedge clk_100);
    chk({tag, "_go_ack"}, w_t'(io_ack), w_t'(exp_go_ack));
    chk({tag, "_go_busy"}, w_t'(vga_busy), w_t'(1'b0));
    tick();
    vga_go = 1'b0;
    io_we  = 1'b0;
    if (scramble) vga_addr = ~a;
    if (rd_addr >= 0) begin
      io_re   = 1'b1;
      io_addr = ADDR_W'(rd_addr);
    end
    for (int j = 1; j <= D; j++) begin
      @(negedge clk_100);
      chk({tag, "_busy"}, w_t'(vga_busy), w_t'(j < D));
      chk({tag, "_done"}, w_t'(vga_done), w_t'(j == D));
      if (rd_addr >= 0) begin
        chk({tag, "_io_ack"}, w_t'(io_ack), w_t'(j == HALF + 1));
        chk({tag, "_io_rvalid"}, w_t'(io_rvalid), w_t'(j == HALF + 1 + RD_LAT));
        if (j == HALF + 1 + RD_LAT) chk({tag, "_io_rdata"}, w_t'(io_rdata), w_t'(DATA_W'(rd_addr)));
      end
      if (j == D) chk({tag, "_lanes"}, w_t'(vga_rdata), w_t'(exp));
      tick();
      if (j == HALF + 1) io_re = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    logic [LANES*ADDR_W-1:0] a, a2, a5;
    logic [LANES*DATA_W-1:0] e, e2, e5;
    for (int k = 0; k < LANES; k++) begin
      a[k*ADDR_W +: ADDR_W]  = ADDR_W'(k + 16);
      e[k*DATA_W +: DATA_W]  = DATA_W'(k + 16);
      a2[k*ADDR_W +: ADDR_W] = ADDR_W'(63 - k);
      e2[k*DATA_W +: DATA_W] = DATA_W'(63 - k);
    end
    a5 = a;
    e5 = e;
    a5[0 +: ADDR_W] = ADDR_W'(16'h0100);
    e5[0 +: DATA_W] = DATA_W'(8'h77);

    rst = 1'b1; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    vga_addr = '0; vga_go = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk_100);
    chk("rst_io_ack", w_t'(io_ack), w_t'(1'b0));
    chk("rst_io_rvalid", w_t'(io_rvalid), w_t'(1'b0));
    chk("rst_vga_busy", w_t'(vga_busy), w_t'(1'b0));
    chk("rst_vga_done", w_t'(vga_done), w_t'(1'b0));
    chk("rst_io_rdata", w_t'(io_rdata), w_t'(0));
    chk("rst_vga_rdata", w_t'(vga_rdata), w_t'(0));
    tick();

    // Single write then read.
    io_we = 1'b1; io_addr = ADDR_W'(16'h1234); io_wdata = DATA_W'(8'hA5);
    @(negedge clk_100);
    chk("wr_ack", w_t'(io_ack), w_t'(1'b1));
    tick();
    io_we = 1'b0; io_re = 1'b1;
    @(negedge clk_100);
    chk("rd_ack", w_t'(io_ack), w_t'(1'b1));
    tick();
    io_re = 1'b0;
    repeat (RD_LAT - 1) begin
      @(negedge clk_100);
      chk("rd_rvalid_early", w_t'(io_rvalid), w_t'(1'b0));
      tick();
    end
    @(negedge clk_100);
    chk("rd_rvalid", w_t'(io_rvalid), w_t'(1'b1));
    chk("rd_data", w_t'(io_rdata), w_t'(8'hA5));
    tick();

    // Preload address i with value i, one write per cycle.
    for (int i = 0; i < 64; i++) begin
      io_we = 1'b1; io_addr = ADDR_W'(i); io_wdata = DATA_W'(i);
      tick();
    end
    io_we = 1'b0;
    tick();

    burst("basic", a, e, 1'b0, -1, 1'b0);
    burst("rev", a2, e2, 1'b0, -1, 1'b0);
    burst("snap", a, e, 1'b1, -1, 1'b0);
    burst("stall", a2, e2, 1'b0, 3, 1'b0);

    // IO write and burst start in the same cycle; lane 0 reads that address.
    io_we = 1'b1; io_addr = ADDR_W'(16'h0100); io_wdata = DATA_W'(8'h77);
    burst("wrgo", a5, e5, 1'b0, -1, 1'b1);

    // Reset in cycle 3 of a burst.
    vga_addr = a; vga_go = 1'b1;
    tick();
    vga_go = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < D + 2; j++) begin
      @(negedge clk_100);
      chk("mrst_busy", w_t'(vga_busy), w_t'(1'b0));
      chk("mrst_done", w_t'(vga_done), w_t'(1'b0));
      chk("mrst_lanes", w_t'(vga_rdata), w_t'(0));
      chk("mrst_io_rdata", w_t'(io_rdata), w_t'(0));
      tick();
    end

    // Reset with an IO read in flight.
    io_re = 1'b1; io_addr = ADDR_W'(5);
    @(negedge clk_100);
    chk("frst_ack", w_t'(io_ack), w_t'(1'b1));
    tick();
    io_re = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < RD_LAT + 2; j++) begin
      @(negedge clk_100);
      chk("frst_rvalid", w_t'(io_rvalid), w_t'(1'b0));
      chk("frst_rdata", w_t'(io_rdata), w_t'(0));
      tick();
    end

    burst("rerun", a, e, 1'b0, -1, 1'b0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
